// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester bus and the UART transmitter/receiver pins of the arbiter.
// Latency: none, wiring only.
// Backpressure: carried by req_valid/req_ready and uart_tx_valid/uart_tx_busy.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
) ();
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [GW-1:0]     grant_id;
    logic              tx_active;
    logic              tx_err;
    logic [7:0]        uart_tx_data;
    logic              uart_tx_valid;
    logic              uart_tx_busy;
    logic [7:0]        uart_rx_word;
    logic              uart_rxne;
    logic              uart_rx_ore;
    logic              uart_rxne_clear;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_overrun;

    // Arbiter side
    modport master (
        input  req_valid, req_data, uart_tx_busy, uart_rx_word, uart_rxne, uart_rx_ore,
        output req_ready, grant_id, tx_active, tx_err, uart_tx_data, uart_tx_valid,
               uart_rxne_clear, rx_data, rx_valid, rx_overrun
    );

    // Requesters and UART side
    modport slave (
        output req_valid, req_data, uart_tx_busy, uart_rx_word, uart_rxne, uart_rx_ore,
        input  req_ready, grant_id, tx_active, tx_err, uart_tx_data, uart_tx_valid,
               uart_rxne_clear, rx_data, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, plus an independent receive capture path.
// Latency: grant and byte latch one cycle after req_valid is seen in IDLE; RX capture one cycle after rxne.
// Backpressure: requesters hold req_valid until req_ready; the transmitter throttles via uart_tx_busy with a start timeout.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int START_TO = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(START_TO + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   to_cnt;
    logic [GW-1:0]   grant_q;
    logic            do_grant;
    logic            do_timeout;
    logic [7:0]      req_byte [NREQ];
    logic [GW:0]     sum_c;
    logic [GW-1:0]   cand_c;
    logic [GW-1:0]   win_c;
    logic            found_c;
    logic            clr_pend;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte
        assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end

    assign bus.grant_id      = grant_q;
    assign bus.tx_active     = (state != IDLE);
    assign bus.uart_tx_valid = (state == START);

    // Pick the first pending requester after the last grant, wrapping around.
    always_comb begin
        sum_c   = '0;
        cand_c  = '0;
        win_c   = '0;
        found_c = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            sum_c = {1'b0, grant_q} + (GW+1)'(k);
            if (sum_c >= (GW+1)'(NREQ)) begin
                sum_c = sum_c - (GW+1)'(NREQ);
            end
            cand_c = sum_c[GW-1:0];
            if (!found_c && bus.req_valid[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the grant/timeout strobes.
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (found_c) begin
                    do_grant  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bus.uart_tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == TW'(START_TO - 1)) begin
                    do_timeout = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, byte latch and the start-timeout counter; the byte only moves on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q          <= GW'(NREQ - 1);
            bus.req_ready    <= '0;
            bus.uart_tx_data <= '0;
            bus.tx_err       <= 1'b0;
            to_cnt           <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.tx_err    <= do_timeout;
            if (do_grant) begin
                grant_q          <= win_c;
                bus.req_ready    <= NREQ'(1) << win_c;
                bus.uart_tx_data <= req_byte[win_c];
            end
            if (state == START && state_nxt == START) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Receive capture: one capture per rxne assertion, re-armed once rxne is seen low.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rx_data         <= '0;
            bus.rx_valid        <= 1'b0;
            bus.uart_rxne_clear <= 1'b0;
            bus.rx_overrun      <= 1'b0;
            clr_pend            <= 1'b0;
        end else begin
            bus.rx_valid        <= 1'b0;
            bus.uart_rxne_clear <= 1'b0;
            if (bus.uart_rxne && !clr_pend) begin
                bus.rx_data         <= bus.uart_rx_word;
                bus.rx_valid        <= 1'b1;
                bus.uart_rxne_clear <= 1'b1;
                clr_pend            <= 1'b1;
            end else if (!bus.uart_rxne) begin
                clr_pend <= 1'b0;
            end
            if (bus.uart_rx_ore) begin
                bus.rx_overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant, round-robin, timeout, RX capture, overrun, reset, loopback.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: the bench plays requesters and the UART by hand.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .START_TO(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},   32'(bus.req_ready), 32'h0);
        check({tag, "_gid"},     32'(bus.grant_id), 32'h3);
        check({tag, "_active"},  32'(bus.tx_active), 32'h0);
        check({tag, "_err"},     32'(bus.tx_err), 32'h0);
        check({tag, "_txvld"},   32'(bus.uart_tx_valid), 32'h0);
        check({tag, "_txdat"},   32'(bus.uart_tx_data), 32'h0);
        check({tag, "_rxclr"},   32'(bus.uart_rxne_clear), 32'h0);
        check({tag, "_rxdat"},   32'(bus.rx_data), 32'h0);
        check({tag, "_rxvld"},   32'(bus.rx_valid), 32'h0);
        check({tag, "_ovr"},     32'(bus.rx_overrun), 32'h0);
    endtask

    // One loopback frame: the sent byte comes back through the receiver after busy falls.
    task automatic serve_frame(input string tag, input logic [7:0] exp_byte);
        int w;
        logic [7:0] b;
        w = 0;
        while (bus.uart_tx_valid !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check({tag, "_start"}, 32'(bus.uart_tx_valid), 32'h1);
        b = bus.uart_tx_data;
        bus.req_valid = '0;
        bus.uart_tx_busy = 1'b1;
        repeat (4) step();
        bus.uart_tx_busy = 1'b0;
        step();
        bus.uart_rx_word = b;
        bus.uart_rxne = 1'b1;
        step();
        check({tag, "_rxvld"}, 32'(bus.rx_valid), 32'h1);
        bus.uart_rxne = 1'b0;
        step();
        check({tag, "_rxdat"}, 32'(bus.rx_data), 32'(exp_byte));
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        int vcnt;
        int cntv;
        int cntc;

        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.uart_tx_busy = 1'b0;
        bus.uart_rx_word = '0;
        bus.uart_rxne    = 1'b0;
        bus.uart_rx_ore  = 1'b0;

        // Reset values, during and just after reset
        repeat (3) step();
        check_reset_state("rst_in");
        rst = 1'b0;
        step();
        check_reset_state("rst_out");

        // Single request from requester 0
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0036;
        step();
        check("single_ready", 32'(bus.req_ready), 32'h1);
        check("single_data",  32'(bus.uart_tx_data), 32'h36);
        check("single_gid",   32'(bus.grant_id), 32'h0);
        check("single_txvld", 32'(bus.uart_tx_valid), 32'h1);
        bus.req_valid = '0;
        step();
        check("single_ready_drop", 32'(bus.req_ready), 32'h0);
        check("single_txvld_hold", 32'(bus.uart_tx_valid), 32'h1);
        bus.uart_tx_busy = 1'b1;
        step();
        check("single_txvld_drop", 32'(bus.uart_tx_valid), 32'h0);
        check("single_active_wd",  32'(bus.tx_active), 32'h1);
        repeat (99) step();
        bus.uart_tx_busy = 1'b0;
        check("single_active_busy", 32'(bus.tx_active), 32'h1);
        step();
        check("single_active_fall", 32'(bus.tx_active), 32'h0);
        check("single_data_hold",   32'(bus.uart_tx_data), 32'h36);

        // Round-robin from a fresh reset with all requesters pending
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h1312_1110;
        for (int g = 0; g < 5; g++) begin
            step();
            check("rr_ready", 32'(bus.req_ready), 32'h1 << rr_exp[g]);
            check("rr_gid",   32'(bus.grant_id), 32'(rr_exp[g]));
            check("rr_data",  32'(bus.uart_tx_data), 32'h10 + 32'(rr_exp[g]));
            bus.uart_tx_busy = 1'b1;
            step();
            check("rr_busy_noready1", 32'(bus.req_ready), 32'h0);
            step();
            check("rr_busy_noready2", 32'(bus.req_ready), 32'h0);
            bus.uart_tx_busy = 1'b0;
            step();
            check("rr_idle", 32'(bus.tx_active), 32'h0);
            if (g == 4) bus.req_valid = '0;
        end

        // Start timeout: busy never rises
        bus.req_valid = 4'b0110;
        step();
        check("to_gid", 32'(bus.grant_id), 32'h1);
        bus.req_valid = 4'b0100;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.uart_tx_valid !== 1'b1) break;
            vcnt++;
            step();
        end
        check("to_valid_cycles", 32'(vcnt), 32'd16);
        check("to_err_pulse",    32'(bus.tx_err), 32'h1);
        check("to_idle",         32'(bus.tx_active), 32'h0);
        step();
        check("to_next_ready", 32'(bus.req_ready), 32'h4);
        check("to_next_data",  32'(bus.uart_tx_data), 32'h12);
        check("to_err_done",   32'(bus.tx_err), 32'h0);
        bus.req_valid = '0;
        bus.uart_tx_busy = 1'b1;
        step();
        bus.uart_tx_busy = 1'b0;
        step();

        // RX: rxne held three cycles gives one capture, re-armed after a low gap
        bus.uart_rx_word = 8'h78;
        bus.uart_rxne = 1'b1;
        cntv = 0;
        cntc = 0;
        repeat (3) begin
            step();
            cntv += int'(bus.rx_valid);
            cntc += int'(bus.uart_rxne_clear);
        end
        bus.uart_rxne = 1'b0;
        step();
        cntv += int'(bus.rx_valid);
        cntc += int'(bus.uart_rxne_clear);
        check("rx_one_valid", 32'(cntv), 32'd1);
        check("rx_one_clear", 32'(cntc), 32'd1);
        check("rx_data_78",   32'(bus.rx_data), 32'h78);
        bus.uart_rx_word = 8'h5a;
        bus.uart_rxne = 1'b1;
        step();
        check("rx_second_valid", 32'(bus.rx_valid), 32'h1);
        check("rx_second_data",  32'(bus.rx_data), 32'h5a);
        bus.uart_rxne = 1'b0;
        step();
        check("rx_second_pulse", 32'(bus.rx_valid), 32'h0);

        // Grant and capture on the same edge
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_00c3;
        bus.uart_rx_word = 8'h42;
        bus.uart_rxne = 1'b1;
        step();
        check("both_ready", 32'(bus.req_ready), 32'h1);
        check("both_rxvld", 32'(bus.rx_valid), 32'h1);
        check("both_rxdat", 32'(bus.rx_data), 32'h42);
        bus.req_valid = '0;
        bus.uart_rxne = 1'b0;
        bus.uart_tx_busy = 1'b1;
        step();
        bus.uart_tx_busy = 1'b0;
        step();

        // Overrun is sticky
        bus.uart_rx_ore = 1'b1;
        step();
        bus.uart_rx_ore = 1'b0;
        repeat (3) step();
        check("ovr_sticky", 32'(bus.rx_overrun), 32'h1);

        // Reset in WAIT_DONE aborts the frame without tx_err
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0099;
        step();
        bus.req_valid = '0;
        bus.uart_tx_busy = 1'b1;
        step();
        check("wd_active", 32'(bus.tx_active), 32'h1);
        rst = 1'b1;
        step();
        check_reset_state("rst_wd");
        rst = 1'b0;
        bus.uart_tx_busy = 1'b0;
        step();
        check("rst_wd_noerr", 32'(bus.tx_err), 32'h0);
        check("rst_wd_idle",  32'(bus.tx_active), 32'h0);

        // Loopback: requester 0 sends 54, requester 1 sends 120
        bus.req_data  = {8'd0, 8'd0, 8'd120, 8'd54};
        bus.req_valid = 4'b0001;
        serve_frame("lb0", 8'd54);
        bus.req_valid = 4'b0010;
        serve_frame("lb1", 8'd120);
        check("lb_overrun", 32'(bus.rx_overrun), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of transmit requesters, range 2..8.
REQ-002 Parameter START_TO, default 16: cycles allowed between uart_tx_valid assertion and uart_tx_busy rising.
REQ-003 clk  in  1  system clock; all logic SHALL be on the rising edge; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NREQ  per-requester byte-pending flag.
REQ-006 req_data  in  NREQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_ready  out  NREQ  one-cycle accept pulse to the granted requester.
REQ-008 grant_id  out  clog2(NREQ)  index of the last granted requester.
REQ-009 tx_active  out  1  high whenever the FSM is not in IDLE.
REQ-010 tx_err  out  1  one-cycle pulse on start timeout.
REQ-011 uart_tx_data  out  8  byte to the UART transmitter.
REQ-012 uart_tx_valid  out  1  start request to the UART transmitter.
REQ-013 uart_tx_busy  in  1  transmitter busy flag.
REQ-014 uart_rx_word  in  8  received byte from the UART receiver.
REQ-015 uart_rxne  in  1  receiver-not-empty flag.
REQ-016 uart_rx_ore  in  1  receiver overrun flag.
REQ-017 uart_rxne_clear  out  1  one-cycle RXNE clear pulse.
REQ-018 rx_data  out  8  last received byte, held until the next capture.
REQ-019 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-020 rx_overrun  out  1  sticky overrun flag.

Function -- transmit
REQ-021 FSM states: IDLE, START, WAIT_DONE.
REQ-022 IDLE: when any req_valid bit is high, grant the first set bit searching from (grant_id+1) mod NREQ upward with wrap-around, pulse that requester's req_ready for exactly one cycle, latch its byte into uart_tx_data, update grant_id, and go to START.
REQ-023 Only one req_ready bit is high in any cycle; no grant is issued outside IDLE.
REQ-024 START: hold uart_tx_valid=1 and uart_tx_data stable; when uart_tx_busy=1, drop uart_tx_valid on the next edge and go to WAIT_DONE.
REQ-025 START timeout: if uart_tx_busy remains 0 for START_TO consecutive cycles in START, drop uart_tx_valid, pulse tx_err, and return to IDLE; the byte is discarded.
REQ-026 WAIT_DONE: return to IDLE on the first cycle in which uart_tx_busy=0, i.e. on the falling edge of busy.
REQ-027 Minimum grant-to-grant spacing is 3 cycles; a requester holding req_valid high is served again only after all other pending requesters have been served once.
REQ-028 uart_tx_data SHALL change only on a grant.

Function -- receive
REQ-029 When uart_rxne=1 and no clear is pending, capture uart_rx_word into rx_data, pulse rx_valid, and pulse uart_rxne_clear, all in the same cycle.
REQ-030 After a clear, no new capture occurs until uart_rxne has been observed at 0 at least once (clear-pending flag).
REQ-031 rx_overrun is set on any cycle with uart_rx_ore=1 and cleared only by rst.
REQ-032 The receive path runs independently of the transmit FSM; simultaneous TX grant and RX capture are both honoured in the same cycle.

Reset
REQ-033 While rst=1, and on the cycle after it deasserts: FSM=IDLE, req_ready=0, grant_id=NREQ-1 (so requester 0 wins first), tx_active=0, tx_err=0, uart_tx_valid=0, uart_tx_data=0, uart_rxne_clear=0, rx_data=0, rx_valid=0, rx_overrun=0, clear-pending=0, timeout counter=0.
REQ-034 Reset asserted mid-frame aborts the current frame immediately with no tx_err, and the granted byte is lost.

Verification
REQ-035 Single request: req_valid=0001, data0=0x36, busy rises 2 cycles after valid and falls 100 cycles later -> req_ready=0001 for 1 cycle, uart_tx_data=0x36, valid drops after busy rises, tx_active falls the cycle after busy falls.
REQ-036 Round-robin: all four req_valid held high with data 0x10..0x13 -> grant order 0,1,2,3,0; never two grants while busy=1.
REQ-037 Timeout: busy held at 0 -> uart_tx_valid high for exactly 16 cycles, then a tx_err pulse, then IDLE, then the next requester is granted.
REQ-038 RX: rxne=1 with word 0x78 held for 3 cycles -> exactly one rx_valid pulse with rx_data=0x78, one rxne_clear pulse; a second rxne after a 0 gap -> second capture.
REQ-039 Overrun and reset: ore pulsed once -> rx_overrun stays 1; rst asserted in WAIT_DONE -> all outputs match REQ-033 the next cycle, and no tx_err.
REQ-040 Loopback: uart_tx_busy and out_signal looped to the receiver, requester 0 sends 54 and requester 1 sends 120 -> rx_data sequence 54, 120, with rx_overrun=0.
